// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two operand sources, the arbiter and the
// result consumer. The arbiter side uses the slave modport.
interface alu_share_arbiter_if;
  logic       req0_valid_in;
  logic [3:0] req0_a_in;
  logic [3:0] req0_b_in;
  logic [2:0] req0_sel_in;
  logic       req0_ready_out;

  logic       req1_valid_in;
  logic [3:0] req1_a_in;
  logic [3:0] req1_b_in;
  logic [2:0] req1_sel_in;
  logic       req1_ready_out;

  logic       rsp_valid_out;
  logic [4:0] rsp_y_out;
  logic       rsp_id_out;
  logic       rsp_ready_in;

  modport slave (
    input  req0_valid_in, req0_a_in, req0_b_in, req0_sel_in,
    output req0_ready_out,
    input  req1_valid_in, req1_a_in, req1_b_in, req1_sel_in,
    output req1_ready_out,
    output rsp_valid_out, rsp_y_out, rsp_id_out,
    input  rsp_ready_in
  );

  modport master (
    output req0_valid_in, req0_a_in, req0_b_in, req0_sel_in,
    input  req0_ready_out,
    output req1_valid_in, req1_a_in, req1_b_in, req1_sel_in,
    input  req1_ready_out,
    input  rsp_valid_out, rsp_y_out, rsp_id_out,
    output rsp_ready_in
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter in front of one shared 4-bit ALU.
// One result slot; a grant happens only when the slot is empty or draining.

// Combinational 4-bit ALU, 5-bit unsigned result.
module basic_alu (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] sel,
  output logic [4:0] y
);
  logic [4:0] a5, b5;
  assign a5 = {1'b0, a};
  assign b5 = {1'b0, b};

  // Opcode decode; arithmetic wraps modulo 32.
  always_comb begin
    y = '0;
    case (sel)
      3'b000: y = a5 + b5;
      3'b001: y = a5 - b5;
      3'b010: y = a5 + 5'd1;
      3'b011: y = a5 - 5'd1;
      3'b100: y = {1'b0, a & b};
      3'b101: y = {1'b0, a | b};
      3'b110: y = {1'b0, a ^ b};
      default: y = {1'b0, ~a};
    endcase
  end
endmodule

module alu_share_arbiter #(
  parameter logic PRIO_RESET = 1'b0
) (
  input logic               clk_in,
  input logic               rst_in,
  alu_share_arbiter_if.slave bus
);
  localparam logic [0:0] SLOT_EMPTY = 1'b0;
  localparam logic [0:0] SLOT_FULL  = 1'b1;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
  } req_t;

  req_t       req [2];
  logic [1:0] req_valid;
  logic [1:0] grant;
  logic       accept;
  logic       prio_q;
  req_t       win;
  logic [4:0] alu_y;

  logic [0:0] slot_q;
  logic [4:0] rsp_y_q;
  logic       rsp_id_q;

  assign req[0]    = '{a: bus.req0_a_in, b: bus.req0_b_in, sel: bus.req0_sel_in};
  assign req[1]    = '{a: bus.req1_a_in, b: bus.req1_b_in, sel: bus.req1_sel_in};
  assign req_valid = {bus.req1_valid_in, bus.req0_valid_in};

  // Slot can take a new result if empty or being drained this cycle.
  assign accept = (slot_q == SLOT_EMPTY) | bus.rsp_ready_in;

  // Round-robin grant; prio_q breaks ties. Nothing is granted under reset.
  always_comb begin
    grant = 2'b00;
    if (accept && !rst_in) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign win = grant[1] ? req[1] : req[0];

  basic_alu u_alu (
    .a   (win.a),
    .b   (win.b),
    .sel (win.sel),
    .y   (alu_y)
  );

  // Result slot and priority pointer; priority moves to the loser on a grant.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slot_q   <= SLOT_EMPTY;
      rsp_y_q  <= '0;
      rsp_id_q <= 1'b0;
      prio_q   <= PRIO_RESET;
    end else if (grant != 2'b00) begin
      slot_q   <= SLOT_FULL;
      rsp_y_q  <= alu_y;
      rsp_id_q <= grant[1];
      prio_q   <= grant[0];
    end else if (bus.rsp_ready_in) begin
      slot_q   <= SLOT_EMPTY;
    end
  end

  assign bus.req0_ready_out = grant[0];
  assign bus.req1_ready_out = grant[1];
  assign bus.rsp_valid_out  = (slot_q == SLOT_FULL);
  assign bus.rsp_y_out      = rsp_y_q;
  assign bus.rsp_id_out     = rsp_id_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed table-driven bench for alu_share_arbiter. Each row is applied
// for one cycle; ready outputs are checked against that row's inputs, the
// registered response against the previous row's grant.
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_share_arbiter_if bus ();

  alu_share_arbiter #(.PRIO_RESET(1'b0)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  typedef struct {
    logic       rst;
    logic       v0;
    logic [3:0] a0, b0;
    logic [2:0] s0;
    logic       v1;
    logic [3:0] a1, b1;
    logic [2:0] s1;
    logic       rdy;
    logic       r0, r1, v;
    logic [4:0] y;
    logic       id;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic rs, input logic v0, input logic [3:0] a0, b0, input logic [2:0] s0,
                     input logic v1, input logic [3:0] a1, b1, input logic [2:0] s1,
                     input logic rdy, input logic r0, r1, v, input logic [4:0] y, input logic id);
    vec_t e;
    e.rst = rs; e.v0 = v0; e.a0 = a0; e.b0 = b0; e.s0 = s0;
    e.v1 = v1; e.a1 = a1; e.b1 = b1; e.s1 = s1; e.rdy = rdy;
    e.r0 = r0; e.r1 = r1; e.v = v; e.y = y; e.id = id;
    tbl.push_back(e);
  endtask

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [3:0] a0, b0, input logic [2:0] s0,
                       input logic v1, input logic [3:0] a1, b1, input logic [2:0] s1, input logic rdy);
    bus.req0_valid_in = v0; bus.req0_a_in = a0; bus.req0_b_in = b0; bus.req0_sel_in = s0;
    bus.req1_valid_in = v1; bus.req1_a_in = a1; bus.req1_b_in = b1; bus.req1_sel_in = s1;
    bus.rsp_ready_in  = rdy;
  endtask

  task automatic chk_all(input string tag, input int idx, input logic r0, r1, v,
                         input logic [4:0] y, input logic id);
    chk({tag, "_ready0"}, idx, {7'd0, bus.req0_ready_out}, {7'd0, r0});
    chk({tag, "_ready1"}, idx, {7'd0, bus.req1_ready_out}, {7'd0, r1});
    chk({tag, "_rsp_valid"}, idx, {7'd0, bus.rsp_valid_out}, {7'd0, v});
    chk({tag, "_rsp_y"}, idx, {3'd0, bus.rsp_y_out}, {3'd0, y});
    chk({tag, "_rsp_id"}, idx, {7'd0, bus.rsp_id_out}, {7'd0, id});
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    //   rst v0 a0 b0 s0  v1 a1 b1 s1 rdy | r0 r1 v  y  id
    // reset with req0 valid: no ready, cleared slot
    add(1, 1, 3, 5, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    // req0, a=3 b=5, every opcode
    add(0, 1, 3, 5, 0,  0, 0, 0, 0, 1,   1, 0, 0, 0, 0);
    add(0, 1, 3, 5, 1,  0, 0, 0, 0, 1,   1, 0, 1, 8, 0);
    add(0, 1, 3, 5, 2,  0, 0, 0, 0, 1,   1, 0, 1, 30, 0);
    add(0, 1, 3, 5, 3,  0, 0, 0, 0, 1,   1, 0, 1, 4, 0);
    add(0, 1, 3, 5, 4,  0, 0, 0, 0, 1,   1, 0, 1, 2, 0);
    add(0, 1, 3, 5, 5,  0, 0, 0, 0, 1,   1, 0, 1, 1, 0);
    add(0, 1, 3, 5, 6,  0, 0, 0, 0, 1,   1, 0, 1, 7, 0);
    add(0, 1, 3, 5, 7,  0, 0, 0, 0, 1,   1, 0, 1, 6, 0);
    // boundaries: dec 0 -> 31, 15+15 -> 30
    add(0, 1, 0, 5, 3,  0, 0, 0, 0, 1,   1, 0, 1, 12, 0);
    add(0, 1, 15, 15, 0, 0, 0, 0, 0, 1,  1, 0, 1, 31, 0);
    // lone req1 hands priority back to 0
    add(0, 0, 0, 0, 0,  1, 2, 2, 0, 1,   0, 1, 1, 30, 0);
    // contention, 6 cycles: 0,1,0,1,0,1 -> results 2,4 alternating
    add(0, 1, 1, 1, 0,  1, 2, 2, 0, 1,   1, 0, 1, 4, 1);
    add(0, 1, 1, 1, 0,  1, 2, 2, 0, 1,   0, 1, 1, 2, 0);
    add(0, 1, 1, 1, 0,  1, 2, 2, 0, 1,   1, 0, 1, 4, 1);
    add(0, 1, 1, 1, 0,  1, 2, 2, 0, 1,   0, 1, 1, 2, 0);
    add(0, 1, 1, 1, 0,  1, 2, 2, 0, 1,   1, 0, 1, 4, 1);
    add(0, 1, 1, 1, 0,  1, 2, 2, 0, 1,   0, 1, 1, 2, 0);
    // backpressure 3 cycles with req1 pending, then drain+grant together
    add(0, 0, 0, 0, 0,  1, 9, 2, 0, 0,   0, 0, 1, 4, 1);
    add(0, 0, 0, 0, 0,  1, 9, 2, 0, 0,   0, 0, 1, 4, 1);
    add(0, 0, 0, 0, 0,  1, 9, 2, 0, 0,   0, 0, 1, 4, 1);
    add(0, 0, 0, 0, 0,  1, 9, 2, 0, 1,   0, 1, 1, 4, 1);
    // drain with no request: valid falls, y/id hold
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 1,   0, 0, 1, 11, 1);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 1,   0, 0, 0, 11, 1);
    // grant into empty slot with consumer stalled (prio -> 1), then hold
    add(0, 1, 5, 1, 0,  0, 0, 0, 0, 0,   1, 0, 0, 11, 1);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 1, 6, 0);
    // reset while FULL, then contention must start with requester 0 again
    add(1, 1, 1, 1, 0,  1, 2, 2, 0, 0,   0, 0, 1, 6, 0);
    add(0, 1, 1, 1, 0,  1, 2, 2, 0, 1,   1, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0,  1, 2, 2, 0, 1,   0, 1, 1, 2, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 1,   0, 0, 1, 4, 1);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 1,   0, 0, 0, 4, 1);

    @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst = tbl[i].rst;
      drive(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].s0,
            tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].s1, tbl[i].rdy);
      #1;
      chk_all("vec", i, tbl[i].r0, tbl[i].r1, tbl[i].v, tbl[i].y, tbl[i].id);
    end

    // Hand sequence: an unconsumed result held under a stalled consumer
    // is thrown away by reset; the slot stays empty afterwards.
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 7, 1, 0, 0);
    #1 chk_all("rstfull_grant", 0, 0, 1, 0, 4, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk_all("rstfull_held", 1, 0, 0, 1, 8, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk_all("rstfull_hold2", 2, 0, 0, 1, 8, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk_all("rstfull_clear", 3, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    #1 chk_all("rstfull_idle", 4, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
